// File: rtl/jogo_pkg.sv
// Shared types for the memory-game controller.
// Holds the 4-bit state codes and the default play timeout.
package jogo_pkg;

  localparam int TIMEOUT_CYCLES_DEF = 5000;

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARA        = 4'h1,
    INICIO_RODADA  = 4'h2,
    ESPERA         = 4'h3,
    REGISTRA       = 4'h4,
    COMPARA        = 4'h5,
    PROXIMA_JOGADA = 4'h6,
    PROXIMA_RODADA = 4'h7,
    FIM_ACERTO     = 4'hA,
    FIM_TIMEOUT    = 4'hD,
    FIM_ERRO       = 4'hE
  } estado_t;

endpackage

// File: rtl/contador_timeout.sv
// Play-timeout counter: counts while conta, saturates, never wraps.
// Ports: clock, reset (async low), zera (clear), conta (count), fim.
module contador_timeout #(
  parameter int M = 5000
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam int W = (M > 1) ? $clog2(M) : 1;
  localparam logic [W-1:0] LAST = W'(M - 1);

  logic [W-1:0] cnt;

  // fim is registered: it rises on the edge that follows the count
  // reaching M-1, i.e. after M full counting cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      fim <= 1'b0;
    end else if (zera) begin
      cnt <= '0;
      fim <= 1'b0;
    end else if (conta) begin
      if (cnt == LAST) begin
        fim <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/unidade_controle_jogo.sv
// Moore controller sequencing the memory-game datapath.
// In: jogar, tem_jogada, igual, fim_rodada, fim_jogo. Out: E/L/R controls,
// pronto/ganhou/perdeu, db_timeout, db_estado (state code).
module unidade_controle_jogo
  import jogo_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic       tem_jogada,
  input  logic       igual,
  input  logic       fim_rodada,
  input  logic       fim_jogo,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraL,
  output logic       contaL,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic       db_timeout,
  output logic [3:0] db_estado
);

  estado_t estado;
  estado_t prox;
  logic    tem_jogada_d;
  logic    jogada;
  logic    fim_t;
  logic    conta_t;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado       <= INICIAL;
      tem_jogada_d <= 1'b0;
    end else begin
      estado       <= prox;
      tem_jogada_d <= tem_jogada;
    end
  end

  // one play per press, however long the button is held
  assign jogada  = tem_jogada & ~tem_jogada_d;
  assign conta_t = (estado == ESPERA);

  contador_timeout #(
    .M(TIMEOUT_CYCLES)
  ) u_timer (
    .clock(clock),
    .reset(reset),
    .zera (~conta_t),
    .conta(conta_t),
    .fim  (fim_t)
  );

  always_comb begin
    prox = INICIAL;
    case (estado)
      INICIAL:        prox = jogar ? PREPARA : INICIAL;
      PREPARA:        prox = INICIO_RODADA;
      INICIO_RODADA:  prox = ESPERA;
      ESPERA: begin
        if (jogada)     prox = REGISTRA;
        else if (fim_t) prox = FIM_TIMEOUT;
        else            prox = ESPERA;
      end
      REGISTRA:       prox = COMPARA;
      COMPARA: begin
        if (!igual)          prox = FIM_ERRO;
        else if (!fim_rodada) prox = PROXIMA_JOGADA;
        else if (!fim_jogo)  prox = PROXIMA_RODADA;
        else                 prox = FIM_ACERTO;
      end
      PROXIMA_JOGADA: prox = ESPERA;
      PROXIMA_RODADA: prox = INICIO_RODADA;
      FIM_ACERTO:     prox = jogar ? PREPARA : FIM_ACERTO;
      FIM_ERRO:       prox = jogar ? PREPARA : FIM_ERRO;
      FIM_TIMEOUT:    prox = jogar ? PREPARA : FIM_TIMEOUT;
      default:        prox = INICIAL;
    endcase
  end

  always_comb begin
    zeraE      = 1'b0;
    contaE     = 1'b0;
    zeraL      = 1'b0;
    contaL     = 1'b0;
    zeraR      = 1'b0;
    registraR  = 1'b0;
    pronto     = 1'b0;
    ganhou     = 1'b0;
    perdeu     = 1'b0;
    db_timeout = 1'b0;
    unique case (1'b1)
      (estado == PREPARA): begin
        zeraE = 1'b1;
        zeraL = 1'b1;
        zeraR = 1'b1;
      end
      (estado == INICIO_RODADA):  zeraE = 1'b1;
      (estado == REGISTRA):       registraR = 1'b1;
      (estado == PROXIMA_JOGADA): contaE = 1'b1;
      (estado == PROXIMA_RODADA): contaL = 1'b1;
      (estado == FIM_ACERTO): begin
        pronto = 1'b1;
        ganhou = 1'b1;
      end
      (estado == FIM_ERRO): begin
        pronto = 1'b1;
        perdeu = 1'b1;
      end
      (estado == FIM_TIMEOUT): begin
        pronto     = 1'b1;
        perdeu     = 1'b1;
        db_timeout = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Bench for unidade_controle_jogo: directed timing checks, then random
// games scored against an event-level game model via a queue.
module tb_unidade_controle_jogo;

  localparam int TO = 8;

  logic       clock, reset, jogar, tem_jogada, igual;
  logic       fim_rodada, fim_jogo;
  logic       zeraE, contaE, zeraL, contaL, zeraR, registraR;
  logic       pronto, ganhou, perdeu, db_timeout;
  logic [3:0] db_estado;

  int vec = 0;
  int miss = 0;
  int n_rounds = 4;
  int de, dl;
  int exp_q[$];
  bit mon_en = 0;
  bit pronto_q = 0;
  int mcode;

  unidade_controle_jogo #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .jogar(jogar),
    .tem_jogada(tem_jogada), .igual(igual),
    .fim_rodada(fim_rodada), .fim_jogo(fim_jogo),
    .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL),
    .contaL(contaL), .zeraR(zeraR), .registraR(registraR),
    .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu),
    .db_timeout(db_timeout), .db_estado(db_estado)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  // datapath stand-in: counters E and L driven by the controller
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      de <= 0;
      dl <= 0;
    end else begin
      if (zeraE) de <= 0;
      else if (contaE) de <= de + 1;
      if (zeraL) dl <= 0;
      else if (contaL) dl <= dl + 1;
    end
  end
  assign fim_rodada = (de == dl);
  assign fim_jogo   = (dl == n_rounds - 1);

  task automatic chk(input string nm, input int act, input int want);
    vec++;
    if (act != want) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d", nm, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int outs();
    return int'({zeraE, contaE, zeraL, contaL, zeraR, registraR,
                 pronto, ganhou, perdeu, db_timeout});
  endfunction

  task automatic wait_st(input int st, input int bound, input string nm);
    int n = 0;
    while (int'(db_estado) != st && n < bound) begin
      tick();
      n++;
    end
    if (int'(db_estado) != st) chk(nm, int'(db_estado), st);
  endtask

  task automatic wait_pronto(input int bound);
    int n = 0;
    while (!pronto && n < bound) begin
      tick();
      n++;
    end
    if (!pronto) chk("wait_pronto", 0, 1);
  endtask

  // event codes: 4 prepare, 5 round start, 1 load R, 2 next pos,
  // 3 next round, 8+{ganhou,perdeu,db_timeout} game end
  always @(negedge clock) begin
    if (mon_en) begin
      mcode = 0;
      if (zeraE && zeraL && zeraR) mcode = 4;
      else if (zeraE) mcode = 5;
      else if (registraR) mcode = 1;
      else if (contaE) mcode = 2;
      else if (contaL) mcode = 3;
      else if (pronto && !pronto_q)
        mcode = 8 + int'({ganhou, perdeu, db_timeout});
      if (mcode != 0) begin
        if (exp_q.size() == 0) begin
          vec++;
          miss++;
          $display("FAIL event: got %0d expected none", mcode);
        end else begin
          chk("event", mcode, exp_q.pop_front());
        end
      end
    end
    pronto_q = pronto;
  end

  int exp_tr[26] = '{1, 2, 3, 3, 3, 4, 5, 7, 2, 3, 3, 4, 5, 6, 3,
                     4, 5, 7, 2, 3, 3, 3, 3, 3, 3, 3};

  initial begin
    int n_reg, n_ce, n_cl, n;
    int acts[$];
    bit done;
    reset = 0; jogar = 0; tem_jogada = 0; igual = 1;
    #2;
    chk("reset_state", int'(db_estado), 0);
    chk("reset_outs", outs(), 0);
    repeat (2) tick();
    reset = 1;
    tick();
    chk("idle_state", int'(db_estado), 0);

    // latency trace over two rounds, jogar held, long button hold
    jogar = 1;
    n_reg = 0; n_ce = 0; n_cl = 0;
    for (int i = 0; i < 26; i++) begin
      tick();
      chk($sformatf("trace%0d", i), int'(db_estado), exp_tr[i]);
      n_reg += int'(registraR);
      n_ce  += int'(contaE);
      n_cl  += int'(contaL);
      if (i == 4) begin jogar = 0; tem_jogada = 1; end
      if (i == 7 || i == 11 || i == 24) tem_jogada = 0;
      if (i == 10 || i == 14) tem_jogada = 1;
    end
    chk("registraR_pulses", n_reg, 3);
    chk("contaE_pulses", n_ce, 1);
    chk("contaL_pulses", n_cl, 2);

    // wrong play
    igual = 0; tem_jogada = 1;
    tick(); chk("err_reg", int'(db_estado), 4);
    tem_jogada = 0;
    tick(); chk("err_cmp", int'(db_estado), 5);
    tick(); chk("err_state", int'(db_estado), 14);
    chk("err_outs", outs(), 10'b0000001010);
    jogar = 1;
    tick(); chk("restart", int'(db_estado), 1);
    jogar = 0;
    tick(); tick();
    chk("esp_entry", int'(db_estado), 3);

    // timeout with no play
    n = 0;
    while (int'(db_estado) != 13 && n < 20) begin
      tick();
      n++;
    end
    chk("timeout_edges", n, 9);
    chk("timeout_outs", outs(), 10'b0000001011);

    // press on 8th edge of ESPERA, single round win
    n_rounds = 1; igual = 1; jogar = 1;
    tick(); jogar = 0;
    tick(); tick();
    repeat (7) tick();
    tem_jogada = 1;
    tick(); chk("press_8th", int'(db_estado), 4);
    tem_jogada = 0;
    tick(); tick();
    chk("win_state", int'(db_estado), 10);
    chk("win_outs", outs(), 10'b0000001100);

    // press coinciding with timeout
    igual = 0; jogar = 1;
    tick(); jogar = 0;
    tick(); tick();
    repeat (8) tick();
    chk("no_to_yet", int'(db_estado), 3);
    tem_jogada = 1;
    tick(); chk("press_tie", int'(db_estado), 4);
    tem_jogada = 0;
    tick(); tick();
    chk("tie_err", int'(db_estado), 14);

    // async reset in ESPERA
    jogar = 1;
    tick(); jogar = 0;
    tick(); tick(); tick();
    #3 reset = 0;
    #1;
    chk("async_state", int'(db_estado), 0);
    chk("async_outs", outs(), 0);
    repeat (3) tick();
    reset = 1;
    repeat (3) tick();
    chk("post_rst_state", int'(db_estado), 0);
    chk("post_rst_outs", outs(), 0);

    // random games against the event model
    mon_en = 1;
    for (int g = 0; g < 30; g++) begin
      n_rounds = $urandom_range(1, 4);
      acts.delete();
      exp_q.push_back(4);
      done = 0;
      for (int r = 0; r < n_rounds && !done; r++) begin
        exp_q.push_back(5);
        for (int p = 0; p <= r && !done; p++) begin
          int a;
          a = $urandom_range(0, 19);
          a = (a < 2) ? 2 : (a < 4) ? 1 : 0;
          acts.push_back(a);
          if (a == 2) begin
            exp_q.push_back(11);
            done = 1;
          end else begin
            exp_q.push_back(1);
            if (a == 1) begin
              exp_q.push_back(10);
              done = 1;
            end else if (p < r) exp_q.push_back(2);
            else if (r < n_rounds - 1) exp_q.push_back(3);
            else exp_q.push_back(12);
          end
        end
      end
      jogar = 1;
      repeat ($urandom_range(1, 3)) tick();
      jogar = 0;
      foreach (acts[k]) begin
        wait_st(3, 20, "wait_espera");
        if (acts[k] == 2) begin
          wait_pronto(3 * TO + 5);
        end else begin
          repeat ($urandom_range(1, 3)) tick();
          igual = (acts[k] == 0);
          tem_jogada = 1;
          repeat ($urandom_range(1, 4)) tick();
          tem_jogada = 0;
        end
      end
      wait_pronto(20);
      tick();
    end
    tick();
    chk("queue_drained", exp_q.size(), 0);
    mon_en = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/unidade_controle_jogo.md
# unidade_controle_jogo

Moore FSM controller that sequences the memory-game datapath (sequence-address counter E, round-limit counter L, play register R, comparators) for the growing-sequence game. Each round replays positions 0..L and ends in win, error or play timeout. It sits between the top level (`jogar`, raw button-activity flag) and the datapath, and owns the play-timeout counter and the play-edge detector.

## Interface
- `TIMEOUT_CYCLES`, default 5000, clock cycles allowed per play (5 s at 1 kHz).
- `clock`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low; forces `INICIAL`.
- `jogar`  in  1  start/restart request, level.
- `tem_jogada`  in  1  any button pressed (datapath OR of `botoes`), level.
- `igual`  in  1  R equals memory[E].
- `fim_rodada`  in  1  E == L (last position of current round).
- `fim_jogo`  in  1  L at its final value (last round).
- `zeraE`, `contaE`  out  1 each  clear / increment E.
- `zeraL`, `contaL`  out  1 each  clear / increment L.
- `zeraR`, `registraR`  out  1 each  clear / load R.
- `pronto`  out  1  game finished.
- `ganhou`  out  1  finished by completing all rounds.
- `perdeu`  out  1  finished by error or timeout.
- `db_timeout`  out  1  finished by timeout.
- `db_estado`  out  4  state code, for the hex display.

## Operation
- Edge detector: `jogada` = `tem_jogada` & ~`tem_jogada_d`. A button held N cycles yields exactly one play.
- State codes (hex) and actions; all outputs are Moore and unlisted outputs are 0:
  - `INICIAL` 0: if `jogar`, go to `PREPARA`.
  - `PREPARA` 1: `zeraE`, `zeraL`, `zeraR`; clear timer; go to `INICIO_RODADA`.
  - `INICIO_RODADA` 2: `zeraE`; clear timer; go to `ESPERA`.
  - `ESPERA` 3: timer counts.
    - `jogada`: go to `REGISTRA`.
    - Timeout, no `jogada`: go to `FIM_TIMEOUT`.
    - Neither: stay.
  - `REGISTRA` 4: `registraR`; clear timer; go to `COMPARA`.
  - `COMPARA` 5:
    - `!igual`: go to `FIM_ERRO`.
    - `igual` & `!fim_rodada`: go to `PROXIMA_JOGADA`.
    - `igual` & `fim_rodada` & `!fim_jogo`: go to `PROXIMA_RODADA`.
    - `igual` & `fim_rodada` & `fim_jogo`: go to `FIM_ACERTO`.
  - `PROXIMA_JOGADA` 6: `contaE`; go to `ESPERA`.
  - `PROXIMA_RODADA` 7: `contaL`; go to `INICIO_RODADA`.
  - `FIM_ACERTO` A: `pronto`, `ganhou`.
  - `FIM_ERRO` E: `pronto`, `perdeu`.
  - `FIM_TIMEOUT` D: `pronto`, `perdeu`, `db_timeout`.
  - From any of A, E, D: `jogar` goes to `PREPARA`.
- Timer: width $clog2(`TIMEOUT_CYCLES`). Counts only in `ESPERA`, cleared in every other state. Timeout asserts when count == `TIMEOUT_CYCLES`-1. It never wraps.
- `jogar` is ignored outside `INICIAL` and the three end states.
- Undefined state codes go to `INICIAL`.

## Timing
- Reset (async, any state): state `INICIAL`, timer 0, `tem_jogada_d` 0. All outputs 0 and `db_estado` = 0 while `reset` is low and after release.
- `jogar` sampled high in `INICIAL` at edge k gives `PREPARA` at k+1 and `ESPERA` at k+3.
- Play latency:
  - `tem_jogada` rising, sampled at edge k in `ESPERA`: `REGISTRA` at k+1, `COMPARA` at k+2.
  - Correct non-final play: back in `ESPERA` at k+4.
  - Correct end of a non-final round: back in `ESPERA` at k+5.
- Timeout: `ESPERA` held with no play for `TIMEOUT_CYCLES` edges, then `FIM_TIMEOUT` on the next edge.
- `jogada` and timeout on the same edge: `jogada` wins.
- Button held across `COMPARA`/`PROXIMA_JOGADA` does not create a second play; a new rising edge is required.
- `igual`, `fim_rodada`, `fim_jogo` are sampled only in `COMPARA`. The datapath must have R loaded by then (one cycle after `registraR`).

## Structure
- Package `jogo_pkg`: 4-bit state enum with the codes above, default `TIMEOUT_CYCLES`.
- Sub-module `contador_timeout` (params `M`; ports `clock`, `reset`, `zera`, `conta`, `fim`).
- Top file holds the state register, next-state logic, output decode and edge detector.

## Test plan
- Reset low mid-`ESPERA` → `db_estado`=0 and all outputs 0 immediately, held after release until `jogar`.
- `jogar` 5 cycles, `fim_jogo`=0. Three correct plays with `fim_rodada`=1 on the third → `db_estado` trace 0,1,2,3,4,5,6,3,…,7,2,3; `contaL` pulses once.
- Button held 10 cycles in `ESPERA` → exactly one `registraR` pulse.
- `igual`=0 in `COMPARA` → `db_estado`=E, `perdeu`=`pronto`=1, `ganhou`=0. Then `jogar` → `PREPARA`.
- `TIMEOUT_CYCLES`=8, no play → `FIM_TIMEOUT` exactly 9 edges after entering `ESPERA`, `db_timeout`=1. Press on the 8th edge instead → `REGISTRA`.
- `fim_rodada`=`fim_jogo`=`igual`=1 in `COMPARA` → `db_estado`=A, `ganhou`=`pronto`=1, `perdeu`=0.
